// File: rtl/pid_share_scheduler.sv
// Shares one PID arithmetic engine across four fan channels: latches error samples,
// issues round-robin engine jobs, keeps per-channel integral/previous-error context.
module pid_share_scheduler #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [3:0]    CLR,
  input  logic [3:0]    SMP_VLD,
  output logic [3:0]    SMP_RDY,
  input  logic [DW-1:0] ERR_IN1,
  input  logic [DW-1:0] ERR_IN2,
  input  logic [DW-1:0] ERR_IN3,
  input  logic [DW-1:0] ERR_IN4,
  output logic          ENG_START,
  output logic [1:0]    ENG_CH,
  output logic [DW-1:0] ENG_ERR,
  output logic [DW-1:0] ENG_INTEG,
  output logic [DW-1:0] ENG_PREV,
  input  logic          ENG_DONE,
  input  logic [DW-1:0] ENG_INTEG_NXT,
  input  logic [DW-1:0] ENG_OUT,
  output logic [DW-1:0] PID_OUT1,
  output logic [DW-1:0] PID_OUT2,
  output logic [DW-1:0] PID_OUT3,
  output logic [DW-1:0] PID_OUT4,
  output logic [3:0]    OUT_VLD,
  output logic [3:0]    OVR,
  output logic          TMO
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] err_in  [NCH];
  logic [DW-1:0] smp     [NCH];
  logic [DW-1:0] integ   [NCH];
  logic [DW-1:0] prev    [NCH];
  logic [DW-1:0] pid_out [NCH];
  logic [3:0]    pending;
  logic [3:0]    accept;
  logic [3:0]    req;
  logic [1:0]    rr;
  logic [1:0]    idx;
  logic [1:0]    gnt_ch;
  logic          found;
  logic          aborted;
  logic          abort_now;
  logic [CW-1:0] tmo_cnt;
  logic          grant;
  logic          done_take;
  logic          tmo_hit;
  logic          wb_end;
  logic          write_ok;
  logic          job_free;

  assign err_in[0] = ERR_IN1;
  assign err_in[1] = ERR_IN2;
  assign err_in[2] = ERR_IN3;
  assign err_in[3] = ERR_IN4;

  assign PID_OUT1 = pid_out[0];
  assign PID_OUT2 = pid_out[1];
  assign PID_OUT3 = pid_out[2];
  assign PID_OUT4 = pid_out[3];

  // One-entry sample latch per channel; a clear blocks acceptance that cycle
  assign SMP_RDY = ~pending & ~CLR;
  assign accept  = SMP_VLD & SMP_RDY;
  assign req     = pending & ~CLR;

  // A clear of the in-flight channel at any point suppresses its write-back
  assign abort_now = aborted | CLR[ENG_CH];
  assign write_ok  = done_take & ~abort_now;
  assign job_free  = (wb_end | tmo_hit) & ~abort_now;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, round-robin arbitration and job-completion strobes
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done_take = 1'b0;
    tmo_hit   = 1'b0;
    wb_end    = 1'b0;
    gnt_ch    = 2'd0;
    found     = 1'b0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_ch = idx;
      end
    end
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (ENG_DONE) begin
          done_take = 1'b1;
          state_nxt = WB;
        end else if (tmo_cnt == CW'(TMO_CYC - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        wb_end    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr        <= 2'd3;
      pending   <= '0;
      aborted   <= 1'b0;
      tmo_cnt   <= '0;
      ENG_START <= 1'b0;
      ENG_CH    <= 2'd0;
      ENG_ERR   <= '0;
      ENG_INTEG <= '0;
      ENG_PREV  <= '0;
      OUT_VLD   <= '0;
      OVR       <= '0;
      TMO       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        smp[i]     <= '0;
        integ[i]   <= '0;
        prev[i]    <= '0;
        pid_out[i] <= '0;
      end
    end else begin
      ENG_START <= grant;
      OUT_VLD   <= '0;

      // Operands are frozen at grant and held until the next grant
      if (grant) begin
        ENG_CH    <= gnt_ch;
        ENG_ERR   <= smp[gnt_ch];
        ENG_INTEG <= integ[gnt_ch];
        ENG_PREV  <= prev[gnt_ch];
        aborted   <= 1'b0;
      end else if (state != IDLE && CLR[ENG_CH]) begin
        aborted <= 1'b1;
      end

      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + CW'(1);

      if (tmo_hit)          TMO <= 1'b1;
      if (wb_end | tmo_hit) rr  <= ENG_CH;

      for (int i = 0; i < NCH; i++) begin
        if (CLR[i]) begin
          integ[i]   <= '0;
          prev[i]    <= '0;
          pending[i] <= 1'b0;
          pid_out[i] <= '0;
          OVR[i]     <= 1'b0;
        end else begin
          if (accept[i]) begin
            smp[i]     <= err_in[i];
            pending[i] <= 1'b1;
          end else if (job_free && ENG_CH == 2'(i)) begin
            pending[i] <= 1'b0;
          end
          if (SMP_VLD[i] && pending[i]) OVR[i] <= 1'b1;
          if (write_ok && ENG_CH == 2'(i)) begin
            integ[i]   <= ENG_INTEG_NXT;
            prev[i]    <= ENG_ERR;
            pid_out[i] <= ENG_OUT;
            OUT_VLD[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_share_scheduler.sv
// Directed bench for pid_share_scheduler: engine model with per-channel latency,
// scoreboard of expected write-backs checked by an independent OUT_VLD monitor.
module tb_pid_share_scheduler;

  logic        CLK;
  logic        nRST;
  logic [3:0]  CLR;
  logic [3:0]  SMP_VLD;
  logic [3:0]  SMP_RDY;
  logic [31:0] ERR_IN1, ERR_IN2, ERR_IN3, ERR_IN4;
  logic        ENG_START;
  logic [1:0]  ENG_CH;
  logic [31:0] ENG_ERR, ENG_INTEG, ENG_PREV;
  logic        ENG_DONE;
  logic [31:0] ENG_INTEG_NXT, ENG_OUT;
  logic [31:0] PID_OUT1, PID_OUT2, PID_OUT3, PID_OUT4;
  logic [3:0]  OUT_VLD;
  logic [3:0]  OVR;
  logic        TMO;

  pid_share_scheduler #(.DW(32), .TMO_CYC(64)) dut (
    .CLK(CLK), .nRST(nRST), .CLR(CLR), .SMP_VLD(SMP_VLD), .SMP_RDY(SMP_RDY),
    .ERR_IN1(ERR_IN1), .ERR_IN2(ERR_IN2), .ERR_IN3(ERR_IN3), .ERR_IN4(ERR_IN4),
    .ENG_START(ENG_START), .ENG_CH(ENG_CH), .ENG_ERR(ENG_ERR),
    .ENG_INTEG(ENG_INTEG), .ENG_PREV(ENG_PREV), .ENG_DONE(ENG_DONE),
    .ENG_INTEG_NXT(ENG_INTEG_NXT), .ENG_OUT(ENG_OUT),
    .PID_OUT1(PID_OUT1), .PID_OUT2(PID_OUT2), .PID_OUT3(PID_OUT3), .PID_OUT4(PID_OUT4),
    .OUT_VLD(OUT_VLD), .OVR(OVR), .TMO(TMO)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] out;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          lat_ch[4];
  bit          force_out;
  logic [31:0] force_val;
  int          e_lat;
  logic [31:0] e_out, e_int;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_err(input int ch, input logic [31:0] v);
    case (ch)
      0: ERR_IN1 = v;
      1: ERR_IN2 = v;
      2: ERR_IN3 = v;
      default: ERR_IN4 = v;
    endcase
  endtask

  // Present one sample for a single edge; returns just after that edge
  task automatic send(input int ch, input logic [31:0] v);
    set_err(ch, v);
    SMP_VLD[ch] = 1'b1;
    tick();
    SMP_VLD = 4'd0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ENG_START) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pid_sel(input logic [3:0] v);
    case (v)
      4'b0001: return PID_OUT1;
      4'b0010: return PID_OUT2;
      4'b0100: return PID_OUT3;
      default: return PID_OUT4;
    endcase
  endfunction

  // Engine model: result = 3*err, integral += err, DONE after lat_ch cycles (0 = never)
  initial begin
    ENG_DONE = 1'b0;
    ENG_OUT = '0;
    ENG_INTEG_NXT = '0;
    forever begin
      tick();
      if (ENG_START === 1'b1) begin
        e_lat = lat_ch[ENG_CH];
        e_out = force_out ? force_val : 32'(ENG_ERR * 3);
        e_int = ENG_INTEG + ENG_ERR;
        if (e_lat > 0) begin
          repeat (e_lat) @(posedge CLK);
          #1;
          ENG_DONE = 1'b1;
          ENG_OUT = e_out;
          ENG_INTEG_NXT = e_int;
          tick();
          ENG_DONE = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      tick();
      if (OUT_VLD !== 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_vld", 32'(OUT_VLD), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_vld", 32'(OUT_VLD), 32'(e.vld));
          chk("pid_out", pid_sel(e.vld), e.out);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    nRST = 1'b0;
    CLR = '0;
    SMP_VLD = '0;
    ERR_IN1 = '0; ERR_IN2 = '0; ERR_IN3 = '0; ERR_IN4 = '0;
    force_out = 1'b0;
    force_val = '0;
    for (int i = 0; i < 4; i++) lat_ch[i] = 1;
    repeat (3) tick();
    chk("rst_start", 32'(ENG_START), 32'd0);
    chk("rst_ch", 32'(ENG_CH), 32'd0);
    chk("rst_outvld", 32'(OUT_VLD), 32'd0);
    chk("rst_ovr", 32'(OVR), 32'd0);
    chk("rst_tmo", 32'(TMO), 32'd0);
    chk("rst_pid1", PID_OUT1, 32'd0);
    chk("rst_rdy", 32'(SMP_RDY), 32'hf);
    nRST = 1'b1;
    tick();

    // Single channel latency and context write-back
    exp_q.push_back('{vld: 4'b0001, out: 32'd300});
    send(0, 32'd100);
    chk("t1_rdy_busy", 32'(SMP_RDY[0]), 32'd0);
    chk("t1_no_start_yet", 32'(ENG_START), 32'd0);
    tick();
    chk("t1_start", 32'(ENG_START), 32'd1);
    chk("t1_ch", 32'(ENG_CH), 32'd0);
    chk("t1_err", ENG_ERR, 32'd100);
    tick();
    chk("t1_start_pulse", 32'(ENG_START), 32'd0);
    chk("t1_vld_early", 32'(OUT_VLD), 32'd0);
    tick();
    chk("t1_vld_lat", 32'(OUT_VLD), 32'b0001);
    tick();
    chk("t1_rdy_free", 32'(SMP_RDY), 32'hf);
    exp_q.push_back('{vld: 4'b0001, out: 32'd150});
    send(0, 32'd50);
    tick();
    chk("t1_prev", ENG_PREV, 32'd100);
    chk("t1_integ", ENG_INTEG, 32'd100);
    repeat (5) tick();

    // Fresh reset so arbitration starts from channel 0
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();

    // Four simultaneous samples, 2-cycle engine
    for (int i = 0; i < 4; i++) lat_ch[i] = 2;
    exp_q.push_back('{vld: 4'b0001, out: 32'd30});
    exp_q.push_back('{vld: 4'b0010, out: 32'd60});
    exp_q.push_back('{vld: 4'b0100, out: 32'd90});
    exp_q.push_back('{vld: 4'b1000, out: 32'd120});
    ERR_IN1 = 32'd10; ERR_IN2 = 32'd20; ERR_IN3 = 32'd30; ERR_IN4 = 32'd40;
    SMP_VLD = 4'hf;
    tick();
    SMP_VLD = 4'd0;
    for (int c = 0; c < 4; c++) begin
      wait_start(ok);
      chk("t2_start_seen", 32'(ok), 32'd1);
      chk("t2_ch_order", 32'(ENG_CH), 32'(c));
    end
    repeat (6) tick();
    chk("t2_rdy_all", 32'(SMP_RDY), 32'hf);

    // Overrun on channel 2
    lat_ch[2] = 3;
    exp_q.push_back('{vld: 4'b0100, out: 32'd21});
    send(2, 32'd7);
    send(2, 32'd9);
    chk("t3_ovr", 32'(OVR), 32'b0100);
    repeat (8) tick();
    chk("t3_ovr_sticky", 32'(OVR), 32'b0100);
    CLR[2] = 1'b1;
    tick();
    CLR = '0;
    chk("t3_ovr_clr", 32'(OVR), 32'd0);
    chk("t3_pid_clr", PID_OUT3, 32'd0);

    // Clear of channel 1 while its job waits on the engine
    lat_ch[1] = 4;
    force_out = 1'b1;
    force_val = 32'd555;
    send(1, 32'd11);
    tick();
    CLR[1] = 1'b1;
    tick();
    CLR = '0;
    repeat (7) tick();
    chk("t4_pid2", PID_OUT2, 32'd0);
    force_out = 1'b0;
    lat_ch[1] = 1;
    exp_q.push_back('{vld: 4'b0010, out: 32'd15});
    send(1, 32'd5);
    tick();
    chk("t4_integ", ENG_INTEG, 32'd0);
    chk("t4_prev", ENG_PREV, 32'd0);
    repeat (5) tick();

    // Engine timeout on channel 0, channel 3 served afterwards
    lat_ch[0] = 0;
    lat_ch[3] = 1;
    send(0, 32'd1);
    tick();
    chk("t5_start", 32'(ENG_START), 32'd1);
    chk("t5_ch0", 32'(ENG_CH), 32'd0);
    exp_q.push_back('{vld: 4'b1000, out: 32'd6});
    send(3, 32'd2);
    repeat (63) tick();
    chk("t5_tmo_early", 32'(TMO), 32'd0);
    tick();
    chk("t5_tmo", 32'(TMO), 32'd1);
    chk("t5_rdy0", 32'(SMP_RDY[0]), 32'd1);
    tick();
    chk("t5_next_start", 32'(ENG_START), 32'd1);
    chk("t5_next_ch", 32'(ENG_CH), 32'd3);
    repeat (4) tick();
    chk("t5_pid1_kept", PID_OUT1, 32'd30);

    // Reset while a job waits; the late DONE must be ignored
    lat_ch[2] = 3;
    send(2, 32'd4);
    tick();
    nRST = 1'b0;
    #1;
    chk("t6_tmo", 32'(TMO), 32'd0);
    chk("t6_pid1", PID_OUT1, 32'd0);
    chk("t6_pid4", PID_OUT4, 32'd0);
    chk("t6_ch", 32'(ENG_CH), 32'd0);
    tick();
    nRST = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (ENG_START || OUT_VLD != 4'd0) seen = 1'b1;
    end
    chk("t6_quiet", 32'(seen), 32'd0);
    chk("t6_rdy", 32'(SMP_RDY), 32'hf);
    chk("t6_ovr", 32'(OVR), 32'd0);

    repeat (3) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
